// File: rtl/id_stage_if.sv
// Bundle between fetch/WB (master) and the decode stage (slave).
// Master drives fetched instruction, stall and WB writes; slave returns decode results and redirect.
interface id_stage_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 5;

  logic [INSTR_W-1:0] if_instr;
  logic [INSTR_W-1:0] if_pcplus4;
  logic               stall;
  logic               wb_we;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  logic               id_valid;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [INSTR_W-1:0] imm_ext;
  logic [ADDR_W-1:0]  rs;
  logic [ADDR_W-1:0]  rt;
  logic [ADDR_W-1:0]  rd;
  logic [5:0]         funct;
  logic               reg_write;
  logic               mem_to_reg;
  logic               mem_write;
  logic               alu_src;
  logic               reg_dst;
  logic [INSTR_W-1:0] targ_addr;
  logic               pc_sel;

  modport master (
    output if_instr, if_pcplus4, stall, wb_we, wb_addr, wb_data,
    input  id_valid, rs_data, rt_data, imm_ext, rs, rt, rd, funct,
           reg_write, mem_to_reg, mem_write, alu_src, reg_dst, targ_addr, pc_sel
  );

  modport slave (
    input  if_instr, if_pcplus4, stall, wb_we, wb_addr, wb_data,
    output id_valid, rs_data, rt_data, imm_ext, rs, rt, rd, funct,
           reg_write, mem_to_reg, mem_write, alu_src, reg_dst, targ_addr, pc_sel
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32-entry register file with write-first bypass,
// opcode decode, and beq/bne/j resolution with redirect back to the fetch PC mux.
module id_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned REG_N   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pcplus4_q;
  logic               valid_q;
  logic [DATA_W-1:0]  regs [REG_N];

  logic [5:0]         opcode;
  logic [ADDR_W-1:0]  rs_a;
  logic [ADDR_W-1:0]  rt_a;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  rt_val;
  logic [INSTR_W-1:0] imm;
  logic               is_r;
  logic               is_addi;
  logic               is_lw;
  logic               is_sw;
  logic               is_beq;
  logic               is_bne;
  logic               is_j;
  logic               operands_eq;
  logic               redirect;

  // IF/ID pipeline register: stall holds, redirect flushes to a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (!bus.stall) begin
      if (redirect) begin
        instr_q   <= NOP_INSTR;
        pcplus4_q <= '0;
        valid_q   <= 1'b0;
      end else begin
        instr_q   <= bus.if_instr;
        pcplus4_q <= bus.if_pcplus4;
        valid_q   <= 1'b1;
      end
    end
  end

  // Register file; r0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_addr != '0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign opcode = instr_q[31:26];
  assign rs_a   = instr_q[25:21];
  assign rt_a   = instr_q[20:16];
  assign imm    = {{16{instr_q[15]}}, instr_q[15:0]};

  // Read ports with write-first bypass from WB
  always_comb begin
    rs_val = regs[rs_a];
    if (rs_a == '0) begin
      rs_val = '0;
    end else if (bus.wb_we && (bus.wb_addr == rs_a)) begin
      rs_val = bus.wb_data;
    end
  end

  always_comb begin
    rt_val = regs[rt_a];
    if (rt_a == '0) begin
      rt_val = '0;
    end else if (bus.wb_we && (bus.wb_addr == rt_a)) begin
      rt_val = bus.wb_data;
    end
  end

  // Opcode decode; a bubble decodes to nothing
  always_comb begin
    is_r    = 1'b0;
    is_addi = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    if (valid_q) begin
      case (opcode)
        OP_RTYPE: is_r    = 1'b1;
        OP_ADDI:  is_addi = 1'b1;
        OP_LW:    is_lw   = 1'b1;
        OP_SW:    is_sw   = 1'b1;
        OP_BEQ:   is_beq  = 1'b1;
        OP_BNE:   is_bne  = 1'b1;
        OP_J:     is_j    = 1'b1;
        default:  ;
      endcase
    end
  end

  assign operands_eq = (rs_val == rt_val);
  assign redirect    = !bus.stall &&
                       (is_j || (is_beq && operands_eq) || (is_bne && !operands_eq));

  assign bus.id_valid   = valid_q;
  assign bus.rs_data    = rs_val;
  assign bus.rt_data    = rt_val;
  assign bus.imm_ext    = imm;
  assign bus.rs         = rs_a;
  assign bus.rt         = rt_a;
  assign bus.rd         = instr_q[15:11];
  assign bus.funct      = instr_q[5:0];
  assign bus.reg_write  = is_r | is_addi | is_lw;
  assign bus.mem_to_reg = is_lw;
  assign bus.mem_write  = is_sw;
  assign bus.alu_src    = is_addi | is_lw | is_sw;
  assign bus.reg_dst    = is_r;
  assign bus.pc_sel     = redirect;

  // Jump keeps the upper PC nibble; branches are PC-relative word offsets
  assign bus.targ_addr = is_j ? {pcplus4_q[31:28], instr_q[25:0], 2'b00}
                              : pcplus4_q + {imm[29:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: an instruction-level model predicts every output each cycle,
// and hand-computed literals at key points pin the model itself.
module tb_id_stage;
  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  id_stage_if #(.DATA_W(32)) bus ();

  id_stage #(.DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic        redirects;
    logic [31:0] targ;
    logic        pc_sel;
  } exp_t;

  // Architectural view held by the model
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_regs [32];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_we === 1'b1 && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [5:0] op;
    logic       eq;
    op = m_instr[31:26];
    e.valid   = m_valid;
    e.rs      = m_instr[25:21];
    e.rt      = m_instr[20:16];
    e.rd      = m_instr[15:11];
    e.funct   = m_instr[5:0];
    e.imm     = 32'($signed(m_instr[15:0]));
    e.rs_data = m_read(e.rs);
    e.rt_data = m_read(e.rt);
    eq        = (e.rs_data == e.rt_data);
    e.reg_write  = m_valid && (op == 6'h00 || op == 6'h08 || op == 6'h23);
    e.mem_to_reg = m_valid && (op == 6'h23);
    e.mem_write  = m_valid && (op == 6'h2B);
    e.alu_src    = m_valid && (op == 6'h08 || op == 6'h23 || op == 6'h2B);
    e.reg_dst    = m_valid && (op == 6'h00);
    e.redirects  = m_valid && ((op == 6'h02) || (op == 6'h04 && eq) || (op == 6'h05 && !eq));
    if (op == 6'h02) e.targ = {m_pc[31:28], m_instr[25:0], 2'b00};
    else             e.targ = m_pc + e.imm * 32'd4;
    e.pc_sel = e.redirects && !bus.stall;
    return e;
  endfunction

  // Model state advances on the same edges as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr <= 32'd0;
      m_pc    <= 32'd0;
      m_valid <= 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      exp_t e;
      e = model_out();
      if (!bus.stall) begin
        if (e.pc_sel) begin
          m_instr <= 32'd0;
          m_pc    <= 32'd0;
          m_valid <= 1'b0;
        end else begin
          m_instr <= bus.if_instr;
          m_pc    <= bus.if_pcplus4;
          m_valid <= 1'b1;
        end
      end
      if (bus.wb_we && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    chk("id_valid",   32'(bus.id_valid),   32'(e.valid));
    chk("rs_data",    bus.rs_data,         e.rs_data);
    chk("rt_data",    bus.rt_data,         e.rt_data);
    chk("imm_ext",    bus.imm_ext,         e.imm);
    chk("rs",         32'(bus.rs),         32'(e.rs));
    chk("rt",         32'(bus.rt),         32'(e.rt));
    chk("rd",         32'(bus.rd),         32'(e.rd));
    chk("funct",      32'(bus.funct),      32'(e.funct));
    chk("reg_write",  32'(bus.reg_write),  32'(e.reg_write));
    chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(e.mem_to_reg));
    chk("mem_write",  32'(bus.mem_write),  32'(e.mem_write));
    chk("alu_src",    32'(bus.alu_src),    32'(e.alu_src));
    chk("reg_dst",    32'(bus.reg_dst),    32'(e.reg_dst));
    chk("pc_sel",     32'(bus.pc_sel),     32'(e.pc_sel));
    if (e.redirects) chk("targ_addr", bus.targ_addr, e.targ);
  end

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] a);
    return {6'h02, a};
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input logic st);
    @(posedge clk);
    #2;
    bus.if_instr   = ins;
    bus.if_pcplus4 = pc4;
    bus.stall      = st;
    bus.wb_we      = 1'b0;
    bus.wb_addr    = 5'd0;
    bus.wb_data    = 32'd0;
  endtask

  task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] filler;
    logic [31:0] beq12;
    filler = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
    beq12  = enc_i(6'h04, 5'd1, 5'd2, 16'd3);
    rst = 1'b0;
    bus.if_instr = 32'd0; bus.if_pcplus4 = 32'd0; bus.stall = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    #1 rst = 1'b1;

    // reset state
    repeat (2) mid();
    chk("lit_reset_valid",  32'(bus.id_valid),  32'd0);
    chk("lit_reset_pcsel",  32'(bus.pc_sel),    32'd0);
    chk("lit_reset_regw",   32'(bus.reg_write), 32'd0);
    chk("lit_reset_rsdata", bus.rs_data,        32'd0);
    chk("lit_reset_rtdata", bus.rt_data,        32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // regfile bypass and r0 protection
    step(enc_r(5'd5, 5'd0, 5'd6, 6'h20), 32'h4, 1'b0);
    step(enc_i(6'h08, 5'd0, 5'd1, 16'd7), 32'h8, 1'b0); set_wb(5'd5, 32'hDEADBEEF);
    mid(); chk("lit_bypass_rs", bus.rs_data, 32'hDEADBEEF);
    chk("lit_rtype_regdst", 32'(bus.reg_dst), 32'd1);
    step(enc_i(6'h08, 5'd0, 5'd2, 16'd7), 32'hC, 1'b0); set_wb(5'd0, 32'h1234);
    mid(); chk("lit_r0_bypass", bus.rs_data, 32'd0);
    step(enc_r(5'd0, 5'd0, 5'd7, 6'h20), 32'h10, 1'b0); set_wb(5'd1, 32'd7);
    mid(); chk("lit_r0_read", bus.rs_data, 32'd0);
    step(32'd0, 32'h14, 1'b0); set_wb(5'd2, 32'd7);

    // taken beq redirects and flushes
    step(beq12, 32'h104, 1'b0);
    step(filler, 32'h108, 1'b0);
    mid(); chk("lit_beq_pcsel", 32'(bus.pc_sel), 32'd1);
    chk("lit_beq_targ", bus.targ_addr, 32'h110);
    step(enc_r(5'd1, 5'd2, 5'd8, 6'h20), 32'h110, 1'b0);
    mid(); chk("lit_flush_valid", 32'(bus.id_valid), 32'd0);

    // jump target and not-taken bne
    step(enc_j(26'h40), 32'h8000_0004, 1'b0);
    mid(); chk("lit_add_rs", bus.rs_data, 32'd7);
    step(filler, 32'h8000_0008, 1'b0);
    mid(); chk("lit_j_pcsel", 32'(bus.pc_sel), 32'd1);
    chk("lit_j_targ", bus.targ_addr, 32'h8000_0100);
    step(enc_i(6'h05, 5'd1, 5'd2, 16'd5), 32'h104, 1'b0);
    step(enc_i(6'h08, 5'd0, 5'd4, 16'd9), 32'h108, 1'b0);
    mid(); chk("lit_bne_nt_pcsel", 32'(bus.pc_sel), 32'd0);
    step(enc_i(6'h2B, 5'd2, 5'd4, 16'd0), 32'h10C, 1'b0);
    mid(); chk("lit_after_bne_valid", 32'(bus.id_valid), 32'd1);
    chk("lit_addi_alusrc", 32'(bus.alu_src), 32'd1);

    // stall holds a taken beq and suppresses redirect
    step(beq12, 32'h200, 1'b0);
    mid(); chk("lit_sw_memwrite", 32'(bus.mem_write), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(filler, 32'h204, 1'b1);
      mid(); chk("lit_stall_pcsel", 32'(bus.pc_sel), 32'd0);
      chk("lit_stall_targ", bus.targ_addr, 32'h20C);
    end
    step(filler, 32'h204, 1'b0);
    mid(); chk("lit_release_pcsel", 32'(bus.pc_sel), 32'd1);
    step(enc_i(6'h23, 5'd2, 5'd3, 16'hFFFC), 32'h20C, 1'b0);
    mid(); chk("lit_release_flush", 32'(bus.id_valid), 32'd0);

    // lw decode, then taken bne with wrap-around target
    step(enc_i(6'h05, 5'd1, 5'd5, 16'h8000), 32'h4, 1'b0);
    mid(); chk("lit_lw_imm", bus.imm_ext, 32'hFFFF_FFFC);
    chk("lit_lw_regw",  32'(bus.reg_write),  32'd1);
    chk("lit_lw_m2r",   32'(bus.mem_to_reg), 32'd1);
    chk("lit_lw_alu",   32'(bus.alu_src),    32'd1);
    chk("lit_lw_regdst", 32'(bus.reg_dst),   32'd0);
    chk("lit_lw_memw",  32'(bus.mem_write),  32'd0);
    step(enc_i(6'h3F, 5'd1, 5'd2, 16'd3), 32'h8, 1'b0);
    mid(); chk("lit_bne_targ", bus.targ_addr, 32'hFFFE_0004);
    step(enc_i(6'h3F, 5'd1, 5'd2, 16'd3), 32'hC, 1'b0);
    step(enc_r(5'd5, 5'd5, 5'd9, 6'h20), 32'h10, 1'b0);
    mid(); chk("lit_unknown_regw", 32'(bus.reg_write), 32'd0);
    step(32'd0, 32'h14, 1'b0); set_wb(5'd5, 32'h55);
    mid(); chk("lit_bypass_rt", bus.rt_data, 32'h55);

    // asynchronous reset in the middle of a taken branch
    step(enc_r(5'd5, 5'd5, 5'd9, 6'h20), 32'h18, 1'b0);
    step(enc_i(6'h04, 5'd5, 5'd5, 16'd1), 32'h1C, 1'b0);
    step(filler, 32'h20, 1'b0);
    mid(); chk("lit_pre_rst_pcsel", 32'(bus.pc_sel), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("lit_async_pcsel", 32'(bus.pc_sel),   32'd0);
    chk("lit_async_valid", 32'(bus.id_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step(enc_r(5'd5, 5'd1, 5'd9, 6'h20), 32'h4, 1'b0);
    step(32'd0, 32'h8, 1'b0);
    mid(); chk("lit_rst_cleared_rs", bus.rs_data, 32'd0);
    chk("lit_rst_cleared_rt", bus.rt_data, 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
